// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the single register-file write port between two
//            writeback requesters (req0: ALU/load path, req1: multi-cycle
//            unit). Each requester owns a one-entry holding buffer with a
//            valid/ready handshake. At most one buffer drains per cycle.
//            Writes to the same register leave in the order they were loaded.
// Ports    : clk, rst (async, active-high)
//            req0_valid/ready/addr/data : requester 0 handshake and payload
//            req1_valid/ready/addr/data : requester 1 handshake and payload
//            rf_we/rf_waddr/rf_wdata    : register-file write port
//            grant                      : one-hot buffer being drained, 00 idle
//            conflict_cnt               : saturating count of both-pending cycles
// Options  : WB_ARB_RR_EN - round-robin resolution of different-address
//            conflicts; fixed priority (buf0 first) when undefined.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [4:0]    req0_addr,
    input  logic [N-1:0]  req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [4:0]    req1_addr,
    input  logic [N-1:0]  req1_data,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [N-1:0]  rf_wdata,
    output logic [1:0]    grant,
    output logic [CW-1:0] conflict_cnt
);

    localparam logic [CW-1:0] c_cntMax = {CW{1'b1}};
    localparam logic [CW-1:0] c_cntOne = {{(CW-1){1'b0}}, 1'b1};

    // Holding buffers
    logic          r_buf0V;
    logic [4:0]    r_buf0Addr;
    logic [N-1:0]  r_buf0Data;
    logic          r_buf1V;
    logic [4:0]    r_buf1Addr;
    logic [N-1:0]  r_buf1Data;
    // 1: buf1 holds the older entry, 0: buf0 holds the older entry
    logic          r_age;
    logic [CW-1:0] r_conflictCnt;

    logic [1:0]    w_grant;
    logic          w_both;
    logic          w_sameAddr;
    logic          w_load0;
    logic          w_load1;
    logic          w_keep0;
    logic          w_keep1;

`ifdef WB_ARB_RR_EN
    // Preferred buffer for the next different-address conflict
    logic          r_rrPtr;
`endif

    assign w_both     = r_buf0V & r_buf1V;
    assign w_sameAddr = (r_buf0Addr == r_buf1Addr);

    always_comb begin
        w_grant = 2'b00;
        if (r_buf0V && !r_buf1V) begin
            w_grant = 2'b01;
        end else if (!r_buf0V && r_buf1V) begin
            w_grant = 2'b10;
        end else if (w_both) begin
            if (w_sameAddr) begin
                // Same destination: older entry first to keep write order
                w_grant = r_age ? 2'b10 : 2'b01;
            end else begin
`ifdef WB_ARB_RR_EN
                w_grant = r_rrPtr ? 2'b10 : 2'b01;
`else
                w_grant = 2'b01;
`endif
            end
        end
    end

    // A buffer draining this cycle can accept a new entry at the same edge
    assign req0_ready = ~r_buf0V | w_grant[0];
    assign req1_ready = ~r_buf1V | w_grant[1];

    // Writes to x0 complete the handshake but are never buffered
    assign w_load0 = req0_valid & req0_ready & (req0_addr != 5'd0);
    assign w_load1 = req1_valid & req1_ready & (req1_addr != 5'd0);

    // Entry still valid after the edge without being reloaded
    assign w_keep0 = r_buf0V & ~w_grant[0];
    assign w_keep1 = r_buf1V & ~w_grant[1];

    always_comb begin
        rf_waddr = 5'd0;
        rf_wdata = '0;
        if (w_grant[0]) begin
            rf_waddr = r_buf0Addr;
            rf_wdata = r_buf0Data;
        end else if (w_grant[1]) begin
            rf_waddr = r_buf1Addr;
            rf_wdata = r_buf1Data;
        end
    end

    assign rf_we        = |w_grant;
    assign grant        = w_grant;
    assign conflict_cnt = r_conflictCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf0V    <= 1'b0;
            r_buf0Addr <= 5'd0;
            r_buf0Data <= '0;
            r_buf1V    <= 1'b0;
            r_buf1Addr <= 5'd0;
            r_buf1Data <= '0;
        end else begin
            if (w_load0) begin
                r_buf0V    <= 1'b1;
                r_buf0Addr <= req0_addr;
                r_buf0Data <= req0_data;
            end else if (w_grant[0]) begin
                r_buf0V    <= 1'b0;
            end
            if (w_load1) begin
                r_buf1V    <= 1'b1;
                r_buf1Addr <= req1_addr;
                r_buf1Data <= req1_data;
            end else if (w_grant[1]) begin
                r_buf1V    <= 1'b0;
            end
        end
    end

    // Simultaneous loads make buf1 older so req0's value lands last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age <= 1'b0;
        end else if (w_load0 && w_load1) begin
            r_age <= 1'b1;
        end else if (w_load0 && w_keep1) begin
            r_age <= 1'b1;
        end else if (w_load1 && w_keep0) begin
            r_age <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflictCnt <= '0;
        end else if (w_both && (r_conflictCnt != c_cntMax)) begin
            r_conflictCnt <= r_conflictCnt + c_cntOne;
        end
    end

`ifdef WB_ARB_RR_EN
    // After a conflict grant, prefer the requester that lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rrPtr <= 1'b0;
        end else if (w_both && !w_sameAddr) begin
            r_rrPtr <= w_grant[0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed, self-checking bench for regfile_write_arbiter.
//            Table of per-cycle vectors plus hand-written sequences for
//            conflicts, same-address ordering, saturation and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int N  = 32;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          req0_valid;
    logic          req0_ready;
    logic [4:0]    req0_addr;
    logic [N-1:0]  req0_data;
    logic          req1_valid;
    logic          req1_ready;
    logic [4:0]    req1_addr;
    logic [N-1:0]  req1_data;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [N-1:0]  rf_wdata;
    logic [1:0]    grant;
    logic [CW-1:0] conflict_cnt;

    int checks;
    int errors;
    int writeCount;
    logic [N-1:0] rfModel [32];

    regfile_write_arbiter #(.N(N), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .grant        (grant),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Register file the write port feeds
    always @(posedge clk) begin
        if (rf_we) begin
            rfModel[rf_waddr] <= rf_wdata;
            writeCount        <= writeCount + 1;
        end
    end

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        eWe;
        logic [4:0]  eAddr;
        logic [31:0] eData;
        logic [1:0]  eGrant;
        logic        eRdy0;
        logic        eRdy1;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(logic v0, logic [4:0] a0, logic [31:0] d0,
                                logic v1, logic [4:0] a1, logic [31:0] d1,
                                logic eWe, logic [4:0] eAddr, logic [31:0] eData,
                                logic [1:0] eGrant, logic eRdy0, logic eRdy1);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.eWe = eWe; v.eAddr = eAddr; v.eData = eData;
        v.eGrant = eGrant; v.eRdy0 = eRdy0; v.eRdy1 = eRdy1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    task automatic checkPort(input string tag, input logic [1:0] eGrant,
                             input logic [4:0] eAddr, input logic [31:0] eData);
        check({tag, " grant"}, {30'd0, grant}, {30'd0, eGrant});
        check({tag, " we"}, {31'd0, rf_we}, {31'd0, |eGrant});
        check({tag, " waddr"}, {27'd0, rf_waddr}, {27'd0, eAddr});
        check({tag, " wdata"}, rf_wdata, eData);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        writeCount = 0;
        for (int i = 0; i < 32; i++) rfModel[i] = '0;
        clk = 1'b0;
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Vectors: inputs applied this cycle, outputs expected this cycle
        vecs[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        2'b00, 1, 1);
        vecs[1]  = mk(0, 5'd0, 32'h0,        1, 5'd0, 32'h1234, 1, 5'd5, 32'hDEADBEEF, 2'b01, 1, 1);
        vecs[2]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        2'b00, 1, 1);
        vecs[3]  = mk(1, 5'd9, 32'hA,        1, 5'd9, 32'hB,    0, 5'd0, 32'h0,        2'b00, 1, 1);
        vecs[4]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd9, 32'hB,        2'b10, 0, 1);
        vecs[5]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd9, 32'hA,        2'b01, 1, 1);
        vecs[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        2'b00, 1, 1);
        vecs[7]  = mk(1, 5'd1, 32'h11,       0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        2'b00, 1, 1);
        vecs[8]  = mk(1, 5'd2, 32'h22,       0, 5'd0, 32'h0,    1, 5'd1, 32'h11,       2'b01, 1, 1);
        vecs[9]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd2, 32'h22,       2'b01, 1, 1);
        vecs[10] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        2'b00, 1, 1);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        checkPort("reset", 2'b00, 5'd0, 32'h0);
        check("reset cnt", {16'd0, conflict_cnt}, 32'd0);
        check("reset rdy0", {31'd0, req0_ready}, 32'd1);
        check("reset rdy1", {31'd0, req1_ready}, 32'd1);

        // Uncontended, x0 discard, same-edge same-address, back-to-back
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            checkPort($sformatf("vec%0d", i), vecs[i].eGrant, vecs[i].eAddr, vecs[i].eData);
            check($sformatf("vec%0d rdy0", i), {31'd0, req0_ready}, {31'd0, vecs[i].eRdy0});
            check($sformatf("vec%0d rdy1", i), {31'd0, req1_ready}, {31'd0, vecs[i].eRdy1});
            @(negedge clk);
        end
        check("rf r5", rfModel[5], 32'hDEADBEEF);
        check("rf r9 same-edge", rfModel[9], 32'hA);
        check("rf r0", rfModel[0], 32'h0);
        check("rf r2", rfModel[2], 32'h22);
        check("cnt after table", {16'd0, conflict_cnt}, 32'd1);

        // Conflict pair 1: addr 3/7
        drive(1, 5'd3, 32'h300, 1, 5'd7, 32'h700);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        checkPort("pair1 c1", 2'b01, 5'd3, 32'h300);
        check("pair1 rdy1 blocked", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        checkPort("pair1 c2", 2'b10, 5'd7, 32'h700);
        check("pair1 cnt", {16'd0, conflict_cnt}, 32'd2);
        @(negedge clk);
        checkPort("pair1 idle", 2'b00, 5'd0, 32'h0);

        // Conflict pair 2: addr 4/8
        drive(1, 5'd4, 32'h400, 1, 5'd8, 32'h800);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
`ifdef WB_ARB_RR_EN
        checkPort("pair2 c1", 2'b10, 5'd8, 32'h800);
        @(negedge clk);
        checkPort("pair2 c2", 2'b01, 5'd4, 32'h400);
`else
        checkPort("pair2 c1", 2'b01, 5'd4, 32'h400);
        @(negedge clk);
        checkPort("pair2 c2", 2'b10, 5'd8, 32'h800);
`endif
        check("pair2 cnt", {16'd0, conflict_cnt}, 32'd3);
        @(negedge clk);
        check("rf r3", rfModel[3], 32'h300);
        check("rf r7", rfModel[7], 32'h700);
        check("rf r4", rfModel[4], 32'h400);
        check("rf r8", rfModel[8], 32'h800);

        // Age: buf1 loads r9 an edge before buf0 loads r9
        drive(1, 5'd3, 32'h33, 1, 5'd9, 32'h99);
        @(negedge clk);
        checkPort("age c1", 2'b01, 5'd3, 32'h33);
        drive(1, 5'd9, 32'h90, 0, 5'd0, 32'h0);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        checkPort("age c2", 2'b10, 5'd9, 32'h99);
        check("age rdy0", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        checkPort("age c3", 2'b01, 5'd9, 32'h90);
        check("age cnt", {16'd0, conflict_cnt}, 32'd5);
        @(negedge clk);
        checkPort("age idle", 2'b00, 5'd0, 32'h0);
        check("rf r9 age", rfModel[9], 32'h90);

        // Saturation: fresh reset, then both continuously valid
        rst = 1'b1;
        #1;
        rst = 1'b0;
        check("sat start cnt", {16'd0, conflict_cnt}, 32'd0);
        drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
        repeat (10) @(negedge clk);
        check("sat early cnt", {16'd0, conflict_cnt}, 32'd9);
        repeat (69990) @(negedge clk);
        check("sat cnt", {16'd0, conflict_cnt}, 32'h0000FFFF);
        checkPort("sat busy", 2'b01, 5'd12, 32'hC0);

        // Reset mid-cycle with both buffers full
        rst = 1'b1;
        #1;
        checkPort("midrst", 2'b00, 5'd0, 32'h0);
        check("midrst cnt", {16'd0, conflict_cnt}, 32'd0);
        check("midrst rdy0", {31'd0, req0_ready}, 32'd1);
        check("midrst rdy1", {31'd0, req1_ready}, 32'd1);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #1;
        rst = 1'b0;
        begin
            int wcBefore;
            wcBefore = writeCount;
            @(negedge clk);
            @(negedge clk);
            check("midrst no write", writeCount, wcBefore);
        end
        checkPort("post rst idle", 2'b00, 5'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
